// File: rtl/mem_port_arbiter.sv
// Multi-port byte-serial memory access arbiter: grants one requester at a time
// and moves 1, 2 or 4 bytes over an 8-bit memory port.
module mem_port_arbiter #(
  parameter int NUM_PORTS = 2,
  parameter int ARB_MODE  = 1,
  parameter int IO_WAIT   = 1
) (
  input  logic                      clk_in,
  input  logic                      rst_in,
  input  logic                      rdy_in,
  input  logic [NUM_PORTS-1:0]      req,
  input  logic [NUM_PORTS-1:0]      we,
  input  logic [32*NUM_PORTS-1:0]   addr,
  input  logic [2*NUM_PORTS-1:0]    len,
  input  logic [NUM_PORTS-1:0]      sgn,
  input  logic [32*NUM_PORTS-1:0]   wdata,
  output logic [NUM_PORTS-1:0]      done,
  output logic [31:0]               rdata,
  output logic                      busy,
  input  logic [7:0]                mem_din,
  output logic [7:0]                mem_dout,
  output logic [31:0]               mem_a,
  output logic                      mem_wr,
  input  logic                      io_buffer_full
);

  localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RD = 2'd1, S_WR = 2'd2, S_DONE = 2'd3} state_t;

  function automatic logic [2:0] len_bytes(input logic [1:0] l);
    case (l)
      2'b00:   len_bytes = 3'd1;
      2'b01:   len_bytes = 3'd2;
      default: len_bytes = 3'd4;
    endcase
  endfunction

  // Past the last byte the read address parks on the final byte.
  function automatic logic [2:0] rd_off(input logic [2:0] c, input logic [2:0] l);
    rd_off = (c < l) ? c : (l - 3'd1);
  endfunction

  function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
    byte_of = w[{i, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] merge_byte(input logic [31:0] b, input logic [7:0] d,
                                             input logic [1:0] i);
    merge_byte = b;
    merge_byte[{i, 3'b000} +: 8] = d;
  endfunction

  function automatic logic [31:0] extend(input logic [31:0] v, input logic [2:0] l, input logic s);
    case (l)
      3'd1:    extend = {{24{s & v[7]}}, v[7:0]};
      3'd2:    extend = {{16{s & v[15]}}, v[15:0]};
      default: extend = v;
    endcase
  endfunction

  function automatic int port_at(input int p, input int i);
    port_at = (ARB_MODE == 1) ? ((p + i) % NUM_PORTS) : i;
  endfunction

  state_t                 state_r;
  logic [2:0]             cnt_r;
  logic [PW-1:0]          ptr_r;
  logic [PW-1:0]          gnt_r;
  logic [31:0]            l_addr_r;
  logic [31:0]            l_wdata_r;
  logic [2:0]             l_len_r;
  logic                   l_sgn_r;
  logic [31:0]            buf_r;
  logic                   refetch_r;
  logic [NUM_PORTS-1:0]   done_r;
  logic [31:0]            rdata_r;
  logic                   busy_r;
  logic [31:0]            mem_a_r;
  logic [7:0]             mem_dout_r;
  logic                   mem_wr_r;

  logic [PW-1:0]          sel_s;
  logic                   found_s;
  logic [PW-1:0]          ptr_nxt_s;
  logic [31:0]            sel_addr_s;
  logic [31:0]            sel_wdata_s;
  logic [2:0]             sel_len_s;
  logic [2:0]             cnt_inc_s;
  logic [31:0]            cap_s;
  logic                   io_stall_s;
  logic [NUM_PORTS-1:0]   gnt_onehot_s;

  // Arbitration: first requester at/after the pointer, or lowest index in fixed mode
  always_comb begin
    sel_s   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (!found_s && req[port_at(int'(ptr_r), i)]) begin
        sel_s   = PW'(port_at(int'(ptr_r), i));
        found_s = 1'b1;
      end else begin
        found_s = found_s;
      end
    end
  end

  assign ptr_nxt_s    = PW'((int'(sel_s) + 1) % NUM_PORTS);
  assign sel_addr_s   = addr[sel_s*32 +: 32];
  assign sel_wdata_s  = wdata[sel_s*32 +: 32];
  assign sel_len_s    = len_bytes(len[sel_s*2 +: 2]);
  assign cnt_inc_s    = cnt_r + 3'd1;
  assign cap_s        = merge_byte(buf_r, mem_din, cnt_r[1:0] - 2'd1);
  assign gnt_onehot_s = NUM_PORTS'(1'b1) << gnt_r;
  assign io_stall_s   = (IO_WAIT != 0) && (state_r == S_WR) && (mem_a_r[17:16] == 2'b11)
                        && io_buffer_full;

  assign done     = done_r & {NUM_PORTS{rdy_in}};
  assign mem_wr   = mem_wr_r & rdy_in & ~io_stall_s;
  assign rdata    = rdata_r;
  assign busy     = busy_r;
  assign mem_a    = mem_a_r;
  assign mem_dout = mem_dout_r;

  // Access FSM with byte sequencing and registered outputs
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_r    <= S_IDLE;
      cnt_r      <= 3'd0;
      ptr_r      <= '0;
      gnt_r      <= '0;
      l_addr_r   <= 32'd0;
      l_wdata_r  <= 32'd0;
      l_len_r    <= 3'd1;
      l_sgn_r    <= 1'b0;
      buf_r      <= 32'd0;
      refetch_r  <= 1'b0;
      done_r     <= '0;
      rdata_r    <= 32'd0;
      busy_r     <= 1'b0;
      mem_a_r    <= 32'd0;
      mem_dout_r <= 8'd0;
      mem_wr_r   <= 1'b0;
    end else if (!rdy_in) begin
      // A byte due during the freeze is lost; point back at it so it can be refetched.
      if (state_r == S_RD && cnt_r != 3'd0) begin
        refetch_r <= 1'b1;
        mem_a_r   <= l_addr_r + {29'd0, cnt_r - 3'd1};
      end else begin
        refetch_r <= refetch_r;
      end
    end else begin
      case (state_r)
        S_IDLE: begin
          if (|req) begin
            gnt_r     <= sel_s;
            ptr_r     <= ptr_nxt_s;
            l_addr_r  <= sel_addr_s;
            l_wdata_r <= sel_wdata_s;
            l_len_r   <= sel_len_s;
            l_sgn_r   <= sgn[sel_s];
            cnt_r     <= 3'd0;
            buf_r     <= 32'd0;
            refetch_r <= 1'b0;
            busy_r    <= 1'b1;
            mem_a_r   <= sel_addr_s;
            if (we[sel_s]) begin
              state_r    <= S_WR;
              mem_dout_r <= sel_wdata_s[7:0];
              mem_wr_r   <= 1'b1;
            end else begin
              state_r <= S_RD;
            end
          end
        end
        S_RD: begin
          if (refetch_r) begin
            refetch_r <= 1'b0;
            mem_a_r   <= l_addr_r + {29'd0, rd_off(cnt_r, l_len_r)};
          end else if (cnt_r == l_len_r) begin
            buf_r   <= cap_s;
            rdata_r <= extend(cap_s, l_len_r, l_sgn_r);
            done_r  <= gnt_onehot_s;
            state_r <= S_DONE;
          end else begin
            if (cnt_r != 3'd0) begin
              buf_r <= cap_s;
            end
            cnt_r   <= cnt_inc_s;
            mem_a_r <= l_addr_r + {29'd0, rd_off(cnt_inc_s, l_len_r)};
          end
        end
        S_WR: begin
          if (io_stall_s) begin
            cnt_r <= cnt_r;
          end else if (cnt_r == l_len_r - 3'd1) begin
            mem_wr_r <= 1'b0;
            done_r   <= gnt_onehot_s;
            rdata_r  <= 32'd0;
            state_r  <= S_DONE;
          end else begin
            cnt_r      <= cnt_inc_s;
            mem_a_r    <= l_addr_r + {29'd0, cnt_inc_s};
            mem_dout_r <= byte_of(l_wdata_r, cnt_inc_s[1:0]);
          end
        end
        S_DONE: begin
          done_r  <= '0;
          rdata_r <= 32'd0;
          busy_r  <= 1'b0;
          cnt_r   <= 3'd0;
          state_r <= S_IDLE;
        end
        default: begin
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: round-robin and fixed-priority instances
// sharing one byte-wide memory model.
module tb_mem_port_arbiter;
  localparam int NP = 3;

  logic clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  logic rst_in, rdy_a, rdy_b, io_a, io_b;
  logic [NP-1:0] req_a, we_a, sgn_a, req_b, we_b, sgn_b;
  logic [32*NP-1:0] addr_a, wdata_a, addr_b, wdata_b;
  logic [2*NP-1:0] len_a, len_b;
  logic [NP-1:0] done_a, done_b;
  logic [31:0] rdata_a, rdata_b, mem_a_a, mem_a_b;
  logic busy_a, busy_b, mem_wr_a, mem_wr_b;
  logic [7:0] mem_dout_a, mem_dout_b;
  logic [7:0] mem_din_a = 8'd0, mem_din_b = 8'd0;

  mem_port_arbiter #(.NUM_PORTS(NP), .ARB_MODE(1), .IO_WAIT(1)) dut_a (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_a), .req(req_a), .we(we_a),
    .addr(addr_a), .len(len_a), .sgn(sgn_a), .wdata(wdata_a), .done(done_a),
    .rdata(rdata_a), .busy(busy_a), .mem_din(mem_din_a), .mem_dout(mem_dout_a),
    .mem_a(mem_a_a), .mem_wr(mem_wr_a), .io_buffer_full(io_a));

  mem_port_arbiter #(.NUM_PORTS(NP), .ARB_MODE(0), .IO_WAIT(1)) dut_b (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_b), .req(req_b), .we(we_b),
    .addr(addr_b), .len(len_b), .sgn(sgn_b), .wdata(wdata_b), .done(done_b),
    .rdata(rdata_b), .busy(busy_b), .mem_din(mem_din_b), .mem_dout(mem_dout_b),
    .mem_a(mem_a_b), .mem_wr(mem_wr_b), .io_buffer_full(io_b));

  typedef struct { int port; logic [31:0] rdata; int cyc; } exp_t;
  typedef struct { logic [31:0] a; logic [7:0] d; int cyc; } wr_t;
  typedef struct { logic [31:0] a; int cyc; } ad_t;

  exp_t exp_q[$];
  exp_t exp_b_q[$];
  wr_t  wr_q[$];
  ad_t  ad_q[$];
  logic [7:0] mem [logic [31:0]];
  int checks = 0;
  int errors = 0;
  int cyc = 0;

  function automatic logic [7:0] rd_mem(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    else return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
    end
  endtask

  // Memory returns the byte addressed in the previous cycle
  always @(posedge clk_in) begin
    mem_din_a <= rd_mem(mem_a_a);
    mem_din_b <= rd_mem(mem_a_b);
    cyc <= cyc + 1;
  end

  // Monitor: pops expected completions, writes and addresses as the DUTs present them
  always @(negedge clk_in) begin : mon
    exp_t e;
    wr_t w;
    ad_t d;
    if (done_a != '0) begin
      if (exp_q.size() == 0) chk("unexpected_done_a", {29'd0, done_a}, 32'd0);
      else begin
        e = exp_q.pop_front();
        chk("done_port_a", {29'd0, done_a}, 32'd1 << e.port);
        chk("rdata_a", rdata_a, e.rdata);
        chk("done_cycle_a", cyc, e.cyc);
      end
    end
    if (done_b != '0) begin
      if (exp_b_q.size() == 0) chk("unexpected_done_b", {29'd0, done_b}, 32'd0);
      else begin
        e = exp_b_q.pop_front();
        chk("done_port_b", {29'd0, done_b}, 32'd1 << e.port);
        chk("rdata_b", rdata_b, e.rdata);
        chk("done_cycle_b", cyc, e.cyc);
      end
    end
    if (mem_wr_b) chk("unexpected_wr_b", {31'd0, mem_wr_b}, 32'd0);
    if (mem_wr_a) begin
      if (wr_q.size() == 0) chk("unexpected_wr_a", {31'd0, mem_wr_a}, 32'd0);
      else begin
        w = wr_q.pop_front();
        chk("wr_addr", mem_a_a, w.a);
        chk("wr_data", {24'd0, mem_dout_a}, {24'd0, w.d});
        chk("wr_cycle", cyc, w.cyc);
      end
    end
    if (ad_q.size() != 0 && ad_q[0].cyc <= cyc) begin
      d = ad_q.pop_front();
      chk("mem_a", mem_a_a, d.a);
      chk("mem_a_cycle", cyc, d.cyc);
    end
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic set_port(input int p, input logic w, input logic [31:0] a, input logic [1:0] l,
                          input logic s, input logic [31:0] dat);
    req_a[p] = 1'b1;
    we_a[p] = w;
    addr_a[32*p +: 32] = a;
    len_a[2*p +: 2] = l;
    sgn_a[p] = s;
    wdata_a[32*p +: 32] = dat;
  endtask

  task automatic push_exp(input int p, input logic [31:0] r, input int c);
    exp_t e;
    e.port = p; e.rdata = r; e.cyc = c;
    exp_q.push_back(e);
  endtask

  task automatic push_exp_b(input int p, input logic [31:0] r, input int c);
    exp_t e;
    e.port = p; e.rdata = r; e.cyc = c;
    exp_b_q.push_back(e);
  endtask

  task automatic push_wr(input logic [31:0] a, input logic [7:0] dat, input int c);
    wr_t w;
    w.a = a; w.d = dat; w.cyc = c;
    wr_q.push_back(w);
  endtask

  task automatic push_ad(input logic [31:0] a, input int c);
    ad_t d;
    d.a = a; d.cyc = c;
    ad_q.push_back(d);
  endtask

  // Wait for every expectation to be consumed, then drop requests in the following IDLE cycle
  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() + exp_b_q.size() + wr_q.size() + ad_q.size()) != 0 && n < 300) begin
      @(negedge clk_in);
      #1;
      n++;
    end
    if (n >= 300) begin
      chk("drain_timeout", exp_q.size() + exp_b_q.size() + wr_q.size() + ad_q.size(), 32'd0);
      exp_q.delete(); exp_b_q.delete(); wr_q.delete(); ad_q.delete();
    end
    @(posedge clk_in);
    #1;
    req_a = '0;
    req_b = '0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_done", {29'd0, done_a}, 32'd0);
    chk("rst_rdata", rdata_a, 32'd0);
    chk("rst_busy", {31'd0, busy_a}, 32'd0);
    chk("rst_mem_a", mem_a_a, 32'd0);
    chk("rst_mem_dout", {24'd0, mem_dout_a}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr_a}, 32'd0);
    chk("rst_busy_b", {31'd0, busy_b}, 32'd0);
    chk("rst_mem_dout_b", {24'd0, mem_dout_b}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int g;
    rst_in = 1'b0; rdy_a = 1'b1; rdy_b = 1'b1; io_a = 1'b0; io_b = 1'b0;
    req_a = '0; we_a = '0; sgn_a = '0; addr_a = '0; wdata_a = '0; len_a = '0;
    req_b = '0; we_b = '0; sgn_b = '0; addr_b = '0; wdata_b = '0; len_b = '0;
    mem[32'h40] = 8'hA0; mem[32'h50] = 8'hB1; mem[32'h60] = 8'hC2;
    mem[32'h100] = 8'h11; mem[32'h101] = 8'h22; mem[32'h102] = 8'h33; mem[32'h103] = 8'h44;
    mem[32'h20] = 8'h80; mem[32'h300] = 8'h34; mem[32'h301] = 8'h92;
    mem[32'h400] = 8'h5A; mem[32'h401] = 8'h6B;

    repeat (3) @(posedge clk_in);
    #3;
    chk_reset_outputs();
    rst_in = 1'b1;
    tick(); tick();

    // All three ports requesting: round-robin 0,1,2,0 versus fixed priority always 0
    for (int p = 0; p < NP; p++) set_port(p, 1'b0, 32'h40 + 32'h10 * p, 2'b00, 1'b0, 32'd0);
    req_b = '1; we_b = '0; sgn_b = '0; len_b = '0; wdata_b = '0;
    addr_b = {32'h60, 32'h50, 32'h40};
    g = cyc;
    push_exp(0, 32'hA0, g + 3); push_exp(1, 32'hB1, g + 7);
    push_exp(2, 32'hC2, g + 11); push_exp(0, 32'hA0, g + 15);
    push_ad(32'h40, g + 1); push_ad(32'h50, g + 5); push_ad(32'h60, g + 9); push_ad(32'h40, g + 13);
    for (int k = 0; k < 4; k++) push_exp_b(0, 32'hA0, g + 3 + 4 * k);
    drain();

    // 4-byte read
    set_port(0, 1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
    g = cyc;
    push_exp(0, 32'h44332211, g + 6);
    for (int k = 0; k < 4; k++) push_ad(32'h100 + k, g + 1 + k);
    drain();

    // Single-byte read, signed then unsigned
    set_port(1, 1'b0, 32'h20, 2'b00, 1'b1, 32'd0);
    g = cyc;
    push_exp(1, 32'hFFFFFF80, g + 3);
    drain();
    set_port(1, 1'b0, 32'h20, 2'b00, 1'b0, 32'd0);
    g = cyc;
    push_exp(1, 32'h00000080, g + 3);
    drain();

    // 2-byte write
    set_port(0, 1'b1, 32'h200, 2'b01, 1'b0, 32'h0000BEEF);
    g = cyc;
    push_wr(32'h200, 8'hEF, g + 1); push_wr(32'h201, 8'hBE, g + 2);
    push_exp(0, 32'd0, g + 3);
    drain();

    // 2-byte signed read
    set_port(2, 1'b0, 32'h300, 2'b01, 1'b1, 32'd0);
    g = cyc;
    push_exp(2, 32'hFFFF9234, g + 4);
    drain();

    // I/O write stalled 5 cycles by a full transmit buffer
    set_port(0, 1'b1, 32'h30000, 2'b00, 1'b0, 32'h41);
    g = cyc;
    push_wr(32'h30000, 8'h41, g + 6);
    push_exp(0, 32'd0, g + 7);
    tick();
    io_a = 1'b1;
    repeat (5) tick();
    io_a = 1'b0;
    drain();

    // Non-I/O write is not stalled by io_buffer_full
    set_port(1, 1'b1, 32'h10000, 2'b10, 1'b0, 32'hDEADBEEF);
    io_a = 1'b1;
    g = cyc;
    push_wr(32'h10000, 8'hEF, g + 1); push_wr(32'h10001, 8'hBE, g + 2);
    push_wr(32'h10002, 8'hAD, g + 3); push_wr(32'h10003, 8'hDE, g + 4);
    push_exp(1, 32'd0, g + 5);
    drain();
    io_a = 1'b0;

    // rdy_in low for two cycles mid-read: the lost byte is refetched
    set_port(0, 1'b0, 32'h400, 2'b01, 1'b0, 32'd0);
    g = cyc;
    push_exp(0, 32'h00006B5A, g + 7);
    push_ad(32'h400, g + 1); push_ad(32'h401, g + 2); push_ad(32'h400, g + 4); push_ad(32'h401, g + 5);
    tick(); tick();
    rdy_a = 1'b0;
    tick(); tick();
    rdy_a = 1'b1;
    drain();

    // Reset during the third byte of a 4-byte read: no done, outputs cleared
    set_port(0, 1'b0, 32'h100, 2'b10, 1'b0, 32'd0);
    g = cyc;
    push_ad(32'h100, g + 1); push_ad(32'h101, g + 2);
    tick(); tick(); tick();
    rst_in = 1'b0;
    req_a = '0;
    @(negedge clk_in);
    chk_reset_outputs();
    tick();
    rst_in = 1'b1;
    tick();

    // After reset the pointer is back at 0: port 0 wins over port 2
    set_port(0, 1'b0, 32'h20, 2'b00, 1'b0, 32'd0);
    set_port(2, 1'b0, 32'h40, 2'b00, 1'b0, 32'd0);
    g = cyc;
    push_exp(0, 32'h80, g + 3);
    push_exp(2, 32'hA0, g + 7);
    drain();
    tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 2, number of requester channels (legal 1..8).
REQ-002 SHALL have parameter ARB_MODE, default 1, arbitration mode: 0 = fixed priority with port 0 highest, 1 = round-robin.
REQ-003 SHALL have parameter IO_WAIT, default 1; 1 = stall I/O writes while io_buffer_full is high, 0 = ignore io_buffer_full.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clk_in and rst_in named as the codebase does.
REQ-005 clk_in  input  1  system clock; all state updates on the rising edge.
REQ-006 rst_in  input  1  asynchronous active-low reset.
REQ-007 rdy_in  input  1  global enable; low freezes all state.
REQ-008 req  input  NUM_PORTS  per-port access request.
REQ-009 we  input  NUM_PORTS  per-port direction: 1 = write, 0 = read.
REQ-010 addr  input  32*NUM_PORTS  per-port byte address; port k occupies bits [32k+31:32k].
REQ-011 len  input  2*NUM_PORTS  per-port access size: 00 = 1 byte, 01 = 2 bytes, 10 and 11 = 4 bytes.
REQ-012 sgn  input  NUM_PORTS  per-port read sign-extension enable.
REQ-013 wdata  input  32*NUM_PORTS  per-port write data, little-endian.
REQ-014 done  output  NUM_PORTS  one-cycle completion pulse for the granted port.
REQ-015 rdata  output  32  read result; valid only while a done bit is high.
REQ-016 busy  output  1  high in any state other than IDLE.
REQ-017 mem_din  input  8  memory read byte, returned one cycle after its address.
REQ-018 mem_dout  output  8  memory write byte.
REQ-019 mem_a  output  32  memory byte address.
REQ-020 mem_wr  output  1  memory write strobe, 1 = write.
REQ-021 io_buffer_full  input  1  UART transmit buffer full.

Function
REQ-022 FSM states SHALL be IDLE, RD, WR and DONE; a byte counter cnt (0..4) and a latched request set (port g, we, addr, L, sgn, wdata) SHALL accompany them.
REQ-023 IDLE: when any req bit is high, the block SHALL select g per ARB_MODE, latch port g's fields and go to RD or WR with cnt=0; mem_wr=0 and mem_a holds its last value.
REQ-024 Round-robin SHALL grant the first requesting port at or after pointer p, wrapping modulo NUM_PORTS; p resets to 0 and becomes g+1 mod NUM_PORTS on each grant.
REQ-025 RD: while cnt<L, mem_a SHALL be addr+cnt (32-bit wrap) with mem_wr=0; while cnt>=1, byte cnt-1 SHALL capture mem_din; cnt increments every cycle; at cnt==L the next state is DONE.
REQ-026 WR: mem_a SHALL be addr+cnt, mem_dout SHALL be wdata byte cnt, mem_wr=1; at cnt==L-1 the next state is DONE.
REQ-027 With IO_WAIT=1, while in WR with mem_a[17:16]==2'b11 and io_buffer_full=1, the block SHALL drive mem_wr=0 and hold cnt.
REQ-028 DONE: done[g] SHALL be 1 for exactly one cycle; in the same cycle rdata SHALL be the assembled read zero- or sign-extended from bit 8L-1 (write: rdata=0); next state is IDLE.
REQ-029 Read latency SHALL be L+2 cycles from the IDLE grant cycle to done; write latency SHALL be L+1 cycles plus any I/O stall cycles.
REQ-030 A requester SHALL hold req and its fields until done; a req still high in the cycle after done SHALL be treated as a new request.
REQ-031 A req deasserted mid-access SHALL NOT abort the access; request changes on non-granted ports SHALL be ignored until IDLE.
REQ-032 rdy_in=0 SHALL freeze state, cnt, p and latched fields, and SHALL force mem_wr=0 and done=0; a read byte arriving during the freeze SHALL be recaptured after rdy_in returns, by re-driving its address for one cycle.

Reset
REQ-033 With rst_in low, the block SHALL go to IDLE with cnt=0 and p=0, and SHALL drive done=0, rdata=0, busy=0, mem_a=0, mem_dout=0 and mem_wr=0, all asynchronously.
REQ-034 Reset asserted mid-access SHALL abandon that access with no done pulse; after reset releases, operation SHALL resume from IDLE on the next rising edge.

Verification
REQ-035 Port0 reads len=10 at 0x100 with memory 0x100..0x103 = 11,22,33,44 -> mem_a 0x100..0x103 on consecutive cycles; done[0] at grant+6; rdata=0x44332211.
REQ-036 Port1 reads len=00 at 0x20 with byte 0x80 and sgn=1 -> rdata=0xFFFFFF80 at grant+3; same read with sgn=0 -> rdata=0x00000080.
REQ-037 Port0 writes len=01, wdata=0xBEEF at 0x200 -> mem_wr=1 with (0x200,EF) then (0x201,BE); done[0] at grant+3.
REQ-038 ARB_MODE=1, NUM_PORTS=3, all ports requesting continuously -> grants follow 0,1,2,0; ARB_MODE=0 under the same stimulus -> grants are always 0.
REQ-039 Port0 writes 0x41 to 0x30000 with io_buffer_full high for 5 cycles -> mem_wr=0 for those 5 cycles, then one write with mem_dout=0x41; done[0] 7 cycles after grant.
REQ-040 rst_in pulsed low during the 3rd byte of a 4-byte read -> no done pulse and all outputs 0; after release, the next request completes normally.
